// File: rtl/bitmap_mem_arb_if.sv
// Bitmap RAM arbiter bundle: video read port, dot-tracer write port, frame-clear
// control and the single-port RAM side. The arbiter takes the slave view.
interface bitmap_mem_arb_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 3
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_rdata;
  logic              vid_rvalid;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  logic              clr_start;
  logic [DATA_W-1:0] clr_color;
  logic              clr_busy;
  logic              clr_done;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vid_req, vid_addr, wr_req, wr_addr, wr_data, clr_start, clr_color, mem_rdata,
    output vid_rdata, vid_rvalid, wr_ack, clr_busy, clr_done, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output vid_req, vid_addr, wr_req, wr_addr, wr_data, clr_start, clr_color, mem_rdata,
    input  vid_rdata, vid_rvalid, wr_ack, clr_busy, clr_done, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/bitmap_mem_arb.sv
// Fixed-priority (video > clear > writer) arbiter for a 1-cycle-latency bitmap RAM; video reads return in 3 cycles, never stalled,
// writer is held off (no wr_ack) while video or a clear owns the RAM. Define CLR_ON_RESET_EN to clear to 0 right after reset.
module bitmap_mem_arb #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 3
) (
  input  logic           clk,
  input  logic           reset,
  bitmap_mem_arb_if.slave bus
);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] clr_color_q, clr_color_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wr_ack_q, wr_ack_d;
  logic              clr_busy_q, clr_busy_d;
  logic              clr_done_q, clr_done_d;
  logic              rd_p1_q, rd_p1_d;
  logic              rd_p2_q, rd_p2_d;
  logic              vid_rvalid_q, vid_rvalid_d;
  logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
  logic              start;
  logic [DATA_W-1:0] start_color;

`ifdef CLR_ON_RESET_EN
  logic init_clr_q, init_clr_d;

  // Held high through reset so the first free cycle behaves like clr_start with colour 0.
  always_comb begin
    init_clr_d  = 1'b0;
    start       = bus.clr_start | init_clr_q;
    start_color = init_clr_q ? '0 : bus.clr_color;
  end

  always_ff @(posedge clk) begin
    if (reset) init_clr_q <= 1'b1;
    else       init_clr_q <= init_clr_d;
  end
`else
  always_comb begin
    start       = bus.clr_start;
    start_color = bus.clr_color;
  end
`endif

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    clr_color_d  = clr_color_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    wr_ack_d     = 1'b0;
    clr_done_d   = 1'b0;
    rd_p1_d      = 1'b0;
    rd_p2_d      = rd_p1_q;
    vid_rvalid_d = rd_p2_q;
    vid_rdata_d  = rd_p2_q ? bus.mem_rdata : vid_rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.vid_req) begin
          mem_addr_d = bus.vid_addr;
          rd_p1_d    = 1'b1;
        end else if (bus.wr_req) begin
          mem_addr_d  = bus.wr_addr;
          mem_wdata_d = bus.wr_data;
          mem_we_d    = 1'b1;
          wr_ack_d    = 1'b1;
        end
        if (start) begin
          state_d     = CLEAR;
          clr_cnt_d   = '0;
          clr_color_d = start_color;
        end
      end
      CLEAR: begin
        if (bus.vid_req) begin
          mem_addr_d = bus.vid_addr;
          rd_p1_d    = 1'b1;
        end else begin
          mem_addr_d  = clr_cnt_q;
          mem_wdata_d = clr_color_q;
          mem_we_d    = 1'b1;
          // Last address: leave without wrapping the counter.
          if (&clr_cnt_q) begin
            state_d    = IDLE;
            clr_done_d = 1'b1;
          end else begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    clr_busy_d = (state_d == CLEAR) | clr_done_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      clr_cnt_q    <= '0;
      clr_color_q  <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      wr_ack_q     <= 1'b0;
      clr_busy_q   <= 1'b0;
      clr_done_q   <= 1'b0;
      rd_p1_q      <= 1'b0;
      rd_p2_q      <= 1'b0;
      vid_rvalid_q <= 1'b0;
      vid_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      clr_color_q  <= clr_color_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      wr_ack_q     <= wr_ack_d;
      clr_busy_q   <= clr_busy_d;
      clr_done_q   <= clr_done_d;
      rd_p1_q      <= rd_p1_d;
      rd_p2_q      <= rd_p2_d;
      vid_rvalid_q <= vid_rvalid_d;
      vid_rdata_q  <= vid_rdata_d;
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.wr_ack     = wr_ack_q;
  assign bus.clr_busy   = clr_busy_q;
  assign bus.clr_done   = clr_done_q;
  assign bus.vid_rvalid = vid_rvalid_q;
  assign bus.vid_rdata  = vid_rdata_q;

endmodule

// File: tb/tb_bitmap_mem_arb.sv
// Bench for bitmap_mem_arb (ADDR_W=4, DATA_W=3): directed scenarios plus random traffic,
// every cycle compared against a transaction-level model with its own shadow of the RAM.
module tb_bitmap_mem_arb;
  localparam int AW = 4;
  localparam int DW = 3;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bitmap_mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bitmap_mem_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Single-port synchronous RAM, 1-cycle read latency.
  logic [DW-1:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // stimulus for the current cycle
  bit          i_rst, i_vid, i_wr, i_clr;
  logic [AW-1:0] i_vaddr, i_waddr;
  logic [DW-1:0] i_wdata, i_ccol;
  bit          drop_on_ack;

  // reference model
  int          cyc = 0;
  bit          has_exp = 0;
  bit          m_clear = 0;
  int          m_cnt = 0;
  logic [DW-1:0] m_color = '0;
  bit          rst_pend = 0;
  logic [DW-1:0] shadow [0:DEPTH-1];
  bit          vpush_v [0:8191];
  logic [DW-1:0] vpush_d [0:8191];
  bit          e_we, e_ack, e_busy, e_done;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  task automatic model();
    bit was_clear, start;
    logic [DW-1:0] col;
    vpush_v[cyc] = 1'b0;
    if (i_rst) begin
      if (cyc >= 1) vpush_v[cyc-1] = 1'b0;
      if (cyc >= 2) vpush_v[cyc-2] = 1'b0;
      m_clear = 0; m_cnt = 0;
      e_we = 0; e_addr = '0; e_wdata = '0; e_ack = 0; e_busy = 0; e_done = 0;
      has_exp = 1;
`ifdef CLR_ON_RESET_EN
      rst_pend = 1;
`else
      rst_pend = 0;
`endif
    end else begin
      was_clear = m_clear;
      start = i_clr || rst_pend;
      col = rst_pend ? '0 : i_ccol;
      rst_pend = 0;
      e_we = 0; e_ack = 0; e_done = 0;
      if (i_vid) begin
        e_addr = i_vaddr;
        vpush_v[cyc] = 1'b1;
        vpush_d[cyc] = shadow[i_vaddr];
      end else if (was_clear) begin
        e_we = 1; e_addr = AW'(m_cnt); e_wdata = m_color;
        shadow[m_cnt] = m_color;
        if (m_cnt == DEPTH-1) begin m_clear = 0; e_done = 1; end
        else m_cnt++;
      end else if (i_wr) begin
        e_we = 1; e_addr = i_waddr; e_wdata = i_wdata; e_ack = 1;
        shadow[i_waddr] = i_wdata;
      end
      if (!was_clear && start) begin
        m_clear = 1; m_cnt = 0; m_color = col;
      end
      e_busy = m_clear || e_done;
    end
  endtask

  // One clock cycle: check this cycle's outputs, drive this cycle's inputs, advance the model.
  task automatic step();
    bit rv;
    @(negedge clk);
    if (has_exp) begin
      chk("mem_we", bus.mem_we, e_we);
      chk("mem_addr", bus.mem_addr, e_addr);
      if (e_we) chk("mem_wdata", bus.mem_wdata, e_wdata);
      chk("wr_ack", bus.wr_ack, e_ack);
      chk("clr_busy", bus.clr_busy, e_busy);
      chk("clr_done", bus.clr_done, e_done);
      rv = (cyc >= 3) ? vpush_v[cyc-3] : 1'b0;
      chk("vid_rvalid", bus.vid_rvalid, rv);
      if (rv) chk("vid_rdata", bus.vid_rdata, vpush_d[cyc-3]);
    end
    if (drop_on_ack && bus.wr_ack) i_wr = 0;
    reset         = i_rst;
    bus.vid_req   = i_vid;
    bus.vid_addr  = i_vaddr;
    bus.wr_req    = i_wr;
    bus.wr_addr   = i_waddr;
    bus.wr_data   = i_wdata;
    bus.clr_start = i_clr;
    bus.clr_color = i_ccol;
    model();
    cyc++;
  endtask

  task automatic idle_wait();
    for (int k = 0; k < 60 && m_clear; k++) step();
    chk("idle_timeout", m_clear, 0);
  endtask

  initial begin
    bit seen_done, got_ack;
    for (int a = 0; a < DEPTH; a++) shadow[a] = '0;
    i_rst = 1; i_vid = 0; i_wr = 0; i_clr = 0;
    i_vaddr = '0; i_waddr = '0; i_wdata = '0; i_ccol = '0;
    drop_on_ack = 1;

    step(); step();
    i_rst = 0;
    step();
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_vid_rvalid", bus.vid_rvalid, 0);
    chk("rst_vid_rdata", bus.vid_rdata, 0);
    chk("rst_wr_ack", bus.wr_ack, 0);
    chk("rst_clr_busy", bus.clr_busy, 0);
    chk("rst_clr_done", bus.clr_done, 0);
    idle_wait();

    // full clear with 3'b111, no video
    i_clr = 1; i_ccol = 3'b111;
    step();
    i_clr = 0;
    step();
    for (int k = 0; k < DEPTH; k++) begin
      step();
      chk("clr_we", bus.mem_we, 1);
      chk("clr_addr", bus.mem_addr, k);
      chk("clr_data", bus.mem_wdata, 3'b111);
      chk("clr_done_at", bus.clr_done, (k == DEPTH-1));
      chk("clr_busy_in", bus.clr_busy, 1);
    end
    step();
    chk("clr_busy_fall", bus.clr_busy, 0);

    // write RAM[5]=101, then read it back through the video port
    i_wr = 1; i_waddr = 4'd5; i_wdata = 3'b101;
    step(); step(); step();
    chk("wr5_dropped", i_wr, 0);
    i_vid = 1; i_vaddr = 4'd5;
    step();
    i_vid = 0;
    step();
    chk("vid_mem_addr", bus.mem_addr, 5);
    chk("vid_mem_we", bus.mem_we, 0);
    step(); step();
    chk("vid_rvalid_n3", bus.vid_rvalid, 1);
    chk("vid_rdata_n3", bus.vid_rdata, 3'b101);

    // video and writer collide: writer goes one cycle later
    i_vid = 1; i_vaddr = 4'd3; i_wr = 1; i_waddr = 4'd7; i_wdata = 3'b010;
    step();
    i_vid = 0;
    step();
    chk("coll_ack_n1", bus.wr_ack, 0);
    step();
    chk("coll_ack_n2", bus.wr_ack, 1);
    chk("coll_we_n2", bus.mem_we, 1);
    chk("coll_addr_n2", bus.mem_addr, 7);
    step();

    // clear stalled by video at clr_cnt=6, pending writer waits for clr_done
    i_wr = 0; i_clr = 1; i_ccol = 3'b011;
    step();
    i_clr = 0; i_wr = 1; i_waddr = 4'd9; i_wdata = 3'b110;
    for (int k = 0; k < 6; k++) step();
    for (int k = 0; k < 4; k++) begin
      i_vid = 1; i_vaddr = 4'($urandom_range(0, DEPTH-1));
      step();
      if (k > 0) chk("stall_we", bus.mem_we, 0);
    end
    i_vid = 0;
    step();
    chk("stall_we", bus.mem_we, 0);
    step();
    chk("resume_we", bus.mem_we, 1);
    chk("resume_addr", bus.mem_addr, 6);
    seen_done = 0; got_ack = 0;
    for (int k = 0; k < 40 && !got_ack; k++) begin
      step();
      if (bus.clr_done) seen_done = 1;
      if (bus.wr_ack) begin
        chk("ack_after_done", seen_done, 1);
        got_ack = 1;
      end
    end
    chk("pending_ack_seen", got_ack, 1);
    i_wr = 0;

    // reset mid-clear at clr_cnt=9
    i_clr = 1; i_ccol = 3'b100;
    step();
    i_clr = 0;
    for (int k = 0; k < 9; k++) step();
    i_rst = 1;
    step();
    i_rst = 0;
    step();
    chk("rst_mid_busy", bus.clr_busy, 0);
    chk("rst_mid_done", bus.clr_done, 0);
    step();
`ifdef CLR_ON_RESET_EN
    chk("auto_clr_busy", bus.clr_busy, 1);
    step();
    chk("auto_clr_we", bus.mem_we, 1);
    chk("auto_clr_addr", bus.mem_addr, 0);
    chk("auto_clr_data", bus.mem_wdata, 0);
`else
    chk("no_auto_clr_busy", bus.clr_busy, 0);
    step();
    chk("no_auto_clr_we", bus.mem_we, 0);
`endif
    idle_wait();

    // random traffic, writer may hold wr_req across acks
    drop_on_ack = 0;
    for (int n = 0; n < 3000; n++) begin
      i_rst   = ($urandom_range(0, 199) == 0);
      i_vid   = ($urandom_range(0, 9) < 3);
      i_vaddr = 4'($urandom_range(0, DEPTH-1));
      i_wr    = ($urandom_range(0, 9) < 4);
      i_waddr = 4'($urandom_range(0, DEPTH-1));
      i_wdata = 3'($urandom_range(0, 7));
      i_clr   = ($urandom_range(0, 39) == 0);
      i_ccol  = 3'($urandom_range(0, 7));
      step();
    end
    i_rst = 0; i_vid = 0; i_wr = 0; i_clr = 0;
    for (int k = 0; k < 4; k++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bitmap_mem_arb.md
BITMAP_MEM_ARB -- requirements
Module: bitmap_mem_arb

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 14, giving the bitmap RAM address width (depth 2^ADDR_W pixels).
REQ-002 The block SHALL have parameter DATA_W, default 3, giving the pixel width (one bit each for R, G, B).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port vid_req, input, 1 bit: video scan read request for the current cycle.
REQ-006 The block SHALL have port vid_addr, input, ADDR_W bits: video read address.
REQ-007 The block SHALL have port vid_rdata, output, DATA_W bits: video read pixel.
REQ-008 The block SHALL have port vid_rvalid, output, 1 bit: vid_rdata valid this cycle.
REQ-009 The block SHALL have port wr_req, input, 1 bit: dot-tracer write request, held until acknowledged.
REQ-010 The block SHALL have port wr_addr, input, ADDR_W bits: dot-tracer write address.
REQ-011 The block SHALL have port wr_data, input, DATA_W bits: dot-tracer write pixel.
REQ-012 The block SHALL have port wr_ack, output, 1 bit: one-cycle pulse marking that the write was issued.
REQ-013 The block SHALL have port clr_start, input, 1 bit: start a full-frame clear (debounced key pulse).
REQ-014 The block SHALL have port clr_color, input, DATA_W bits: fill value, sampled with clr_start.
REQ-015 The block SHALL have port clr_busy, output, 1 bit: clear in progress.
REQ-016 The block SHALL have port clr_done, output, 1 bit: one-cycle pulse when the clear completes.
REQ-017 The block SHALL have ports mem_addr (output, ADDR_W bits), mem_we (output, 1 bit), mem_wdata (output, DATA_W bits) and mem_rdata (input, DATA_W bits), driving a single-port synchronous RAM with 1-cycle read latency.

Function
REQ-018 Grant SHALL be decided each cycle n with fixed priority video > clear > writer; the winner's mem_addr/mem_we/mem_wdata SHALL be registered and driven in cycle n+1.
REQ-019 A video grant SHALL drive mem_we=0; mem_rdata arrives in n+2; vid_rdata/vid_rvalid SHALL be registered and valid in n+3 (fixed 3-cycle latency, never stalled).
REQ-020 vid_req SHALL always be granted in the cycle asserted; back-to-back vid_req SHALL yield back-to-back vid_rvalid.
REQ-021 A writer grant SHALL assert mem_we=1 with wr_addr/wr_data in n+1 and pulse wr_ack in n+1; wr_req still high in n+1 SHALL be treated as a new request.
REQ-022 FSM states SHALL be IDLE and CLEAR; IDLE->CLEAR on clr_start, latching clr_color and loading clr_cnt=0; clr_start in CLEAR SHALL be ignored.
REQ-023 In CLEAR, each cycle without vid_req SHALL write clr_color to address clr_cnt and increment clr_cnt; cycles with vid_req SHALL hold clr_cnt.
REQ-024 After writing address 2^ADDR_W-1, the FSM SHALL return to IDLE with clr_done pulsed in the cycle that last write appears on mem_*; clr_cnt SHALL NOT wrap.
REQ-025 clr_busy SHALL be 1 from the cycle after clr_start through the clr_done cycle inclusive.
REQ-026 In CLEAR, wr_req SHALL NOT be acknowledged; the writer waits until IDLE.
REQ-027 With no grant, mem_we SHALL be 0 and mem_addr SHALL hold its previous value.

Reset
REQ-028 When reset is high at a clock edge, the block SHALL force FSM=IDLE, clr_cnt=0, mem_we=0, mem_addr=0, mem_wdata=0, vid_rdata=0, vid_rvalid=0, wr_ack=0, clr_busy=0 and clr_done=0, discarding any in-flight reads.
REQ-029 A reset asserted mid-clear SHALL abandon the clear without a clr_done pulse.

Configuration
REQ-030 With macro CLR_ON_RESET_EN defined, the first cycle after reset deasserts SHALL enter CLEAR with fill value 0, as if clr_start and clr_color=0 were applied; without it, the block SHALL remain in IDLE until clr_start.

Verification (bench overrides ADDR_W=4, DATA_W=3)
REQ-031 vid_req=1, vid_addr=5, RAM[5]=3'b101 -> mem_addr=5, mem_we=0 at n+1; vid_rdata=3'b101, vid_rvalid=1 at n+3.
REQ-032 vid_req and wr_req (addr 7, data 3'b010) in the same cycle -> video granted; wr_ack at n+2 with mem_we=1, mem_addr=7.
REQ-033 clr_start with clr_color=3'b111 and no video -> 16 consecutive writes to addresses 0..15; clr_done coincides with the address-15 write; clr_busy falls the cycle after.
REQ-034 Clear running, vid_req held high for 4 cycles at clr_cnt=6 -> no clear writes during those cycles, resumes at address 6; pending wr_req acked only after clr_done.
REQ-035 reset at clr_cnt=9 -> clr_busy=0 next cycle, no clr_done; with CLR_ON_RESET_EN defined, a new clear of color 0 starts at address 0 after reset deasserts.
